// File: rtl/muldiv_e_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : muldiv_e_pkg                                                      |
// | Brief  : Shared types for the E-stage multiply/divide unit: md_op          |
// |          encodings, FSM state type, and small elaboration helpers.         |
// | Ports  : none (package)                                                    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package muldiv_e_pkg;

   // Operation selector driven by the decoder alongside the alu_* ops.
   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6
   } md_op_e;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // True for the four ops that occupy the unit for a multi-cycle latency.
   function automatic logic is_md_start(input md_op_e op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_e_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : muldiv_e_if                                                       |
// | Brief  : E-stage <-> multiply/divide unit bundle.                          |
// |   start  : E-stage instr is mult/multu/div/divu                            |
// |   md_op  : operation selector (md_op_e)                                    |
// |   SrcA   : forwarded rs operand, SrcB : forwarded rt operand               |
// |   req    : exception/interrupt flush                                       |
// |   busy   : md operation in flight; HI/LO : architectural registers         |
// |   master = pipeline side, slave = muldiv_e                                 |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
interface muldiv_e_if;
   import muldiv_e_pkg::*;

   logic        start;
   md_op_e      md_op;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic        req;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (
      output start, md_op, SrcA, SrcB, req,
      input  busy, HI, LO
   );

   modport slave (
      input  start, md_op, SrcA, SrcB, req,
      output busy, HI, LO
   );

endinterface
`default_nettype wire

// File: rtl/muldiv_e.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : muldiv_e                                                          |
// | Brief  : Multi-cycle multiply/divide unit in the E stage. Accepts          |
// |          mult/multu/div/divu, holds busy for a fixed latency, then commits |
// |          HI/LO. Also serves mthi/mtlo and exposes HI/LO for forwarding.    |
// | Ports  : clk   - rising-edge clock                                         |
// |          reset - synchronous, active-high                                  |
// |          md    - muldiv_e_if.slave (start, md_op, SrcA, SrcB, req,         |
// |                  busy, HI, LO)                                             |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module muldiv_e
   import muldiv_e_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic     clk,
   input  logic     reset,
   muldiv_e_if.slave md
);

   localparam int CNT_W = $clog2(max_u(MULT_CYCLES, DIV_CYCLES) + 1);

   md_state_e   state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic [31:0] pend_hi, pend_hi_d;
   logic [31:0] pend_lo, pend_lo_d;
   logic        pend_wr, pend_wr_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic        accept;
   logic        is_mult;
   logic        is_sdiv;
   logic        b_zero;
   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [31:0] a_mag, b_mag;
   logic [31:0] dvd, dvs;
   logic [31:0] uq, ur;
   logic [31:0] quo, rem;

   assign accept  = (state == ST_IDLE) && md.start && !md.req && is_md_start(md.md_op);
   assign is_mult = (md.md_op == MD_MULT) || (md.md_op == MD_MULTU);
   assign is_sdiv = (md.md_op == MD_DIV);
   assign b_zero  = (md.SrcB == 32'd0);

   // Operands widened to 64 bits so the product is not truncated.
   assign prod_u = {32'd0, md.SrcA} * {32'd0, md.SrcB};
   assign prod_s = $signed({{32{md.SrcA[31]}}, md.SrcA}) * $signed({{32{md.SrcB[31]}}, md.SrcB});

   // Signed divide is done on magnitudes and re-signed afterwards. This makes
   // 0x80000000 / -1 come out as LO=0x80000000, HI=0 without relying on the
   // simulator's handling of signed overflow.
   assign a_mag = md.SrcA[31] ? (32'd0 - md.SrcA) : md.SrcA;
   assign b_mag = md.SrcB[31] ? (32'd0 - md.SrcB) : md.SrcB;
   assign dvd   = is_sdiv ? a_mag : md.SrcA;
   // A zero divisor is replaced by 1 only to keep the operator well defined;
   // the result is discarded through pend_wr.
   assign dvs   = b_zero ? 32'd1 : (is_sdiv ? b_mag : md.SrcB);
   assign uq    = dvd / dvs;
   assign ur    = dvd % dvs;
   assign quo   = (is_sdiv && (md.SrcA[31] ^ md.SrcB[31])) ? (32'd0 - uq) : uq;
   assign rem   = (is_sdiv && md.SrcA[31]) ? (32'd0 - ur) : ur;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
         pend_wr <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state   <= state_d;
         cnt     <= cnt_d;
         pend_hi <= pend_hi_d;
         pend_lo <= pend_lo_d;
         pend_wr <= pend_wr_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      pend_hi_d = pend_hi;
      pend_lo_d = pend_lo;
      pend_wr_d = pend_wr;
      hi_d      = hi_q;
      lo_d      = lo_q;

      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_d   = ST_RUN;
               cnt_d     = is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
               pend_wr_d = is_mult || !b_zero;
               case (md.md_op)
                  MD_MULT: begin
                     pend_hi_d = prod_s[63:32];
                     pend_lo_d = prod_s[31:0];
                  end
                  MD_MULTU: begin
                     pend_hi_d = prod_u[63:32];
                     pend_lo_d = prod_u[31:0];
                  end
                  default: begin
                     pend_hi_d = rem;
                     pend_lo_d = quo;
                  end
               endcase
            end else if (!md.req) begin
               if (md.md_op == MD_MTHI) hi_d = md.SrcA;
               if (md.md_op == MD_MTLO) lo_d = md.SrcA;
            end
         end
         ST_RUN: begin
            // req is deliberately ignored here: the op was already issued.
            cnt_d = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               state_d = ST_IDLE;
               if (pend_wr) begin
                  hi_d = pend_hi;
                  lo_d = pend_lo;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign md.busy = (state == ST_RUN);
   assign md.HI   = hi_q;
   assign md.LO   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_e.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_muldiv_e                                                       |
// | Brief  : Self-checking bench for muldiv_e: directed scenarios plus random  |
// |          traffic compared every cycle against a behavioural HI/LO model.   |
// | Ports  : none                                                              |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_muldiv_e;
   import muldiv_e_pkg::*;

   localparam int MC = 5;
   localparam int DC = 10;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   logic chk_en;

   muldiv_e_if mif ();

   muldiv_e #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk  (clk),
      .reset(reset),
      .md   (mif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [31:0] m_hi, m_lo, m_phi, m_plo;
   logic        m_pwr;
   int          m_rem;
   logic [64:0] ref_now;

   // {write_enable, hi, lo} straight from the arithmetic rules.
   function automatic logic [64:0] ref_result(input md_op_e op, input logic [31:0] a,
                                             input logic [31:0] b);
      longint          sa, sb, sq, sr, sp;
      longint unsigned ua, ub, up;
      logic [63:0]     v;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         MD_MULT:  begin sp = sa * sb; v = sp; return {1'b1, v}; end
         MD_MULTU: begin up = ua * ub; v = up; return {1'b1, v}; end
         MD_DIV: begin
            if (b == 0) return {1'b0, 64'd0};
            sq = sa / sb;
            sr = sa % sb;
            return {1'b1, sr[31:0], sq[31:0]};
         end
         MD_DIVU: begin
            if (b == 0) return {1'b0, 64'd0};
            return {1'b1, a % b, a / b};
         end
         default: return {1'b0, 64'd0};
      endcase
   endfunction

   assign ref_now = ref_result(mif.md_op, mif.SrcA, mif.SrcB);

   initial begin
      m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_pwr = 1'b0; m_rem = 0;
   end

   always @(posedge clk) begin
      if (reset) begin
         m_hi  <= '0;
         m_lo  <= '0;
         m_rem <= 0;
      end else if (m_rem != 0) begin
         if (mif.start) begin
            errors = errors + 1;
            $display("FAIL start_while_busy: start=1 while model has %0d cycles left, required start=0", m_rem);
         end
         if (m_rem == 1 && m_pwr) begin
            m_hi <= m_phi;
            m_lo <= m_plo;
         end
         m_rem <= m_rem - 1;
      end else if (mif.start && !mif.req &&
                   (mif.md_op == MD_MULT || mif.md_op == MD_MULTU ||
                    mif.md_op == MD_DIV  || mif.md_op == MD_DIVU)) begin
         m_pwr <= ref_now[64];
         m_phi <= ref_now[63:32];
         m_plo <= ref_now[31:0];
         m_rem <= (mif.md_op == MD_MULT || mif.md_op == MD_MULTU) ? MC : DC;
      end else if (!mif.req) begin
         if (mif.md_op == MD_MTHI) m_hi <= mif.SrcA;
         if (mif.md_op == MD_MTLO) m_lo <= mif.SrcA;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         checks = checks + 1;
         if (mif.busy !== (m_rem != 0) || mif.HI !== m_hi || mif.LO !== m_lo) begin
            errors = errors + 1;
            $display("FAIL cycle_compare t=%0t: busy=%b HI=%h LO=%h, required busy=%b HI=%h LO=%h",
                     $time, mif.busy, mif.HI, mif.LO, (m_rem != 0), m_hi, m_lo);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic drive(input md_op_e op, input logic st, input logic [31:0] a,
                        input logic [31:0] b, input logic rq);
      mif.md_op = op;
      mif.start = st;
      mif.SrcA  = a;
      mif.SrcB  = b;
      mif.req   = rq;
      step();
      mif.md_op = MD_NONE;
      mif.start = 1'b0;
      mif.req   = 1'b0;
   endtask

   // Idle the inputs until the op completes; req toggles randomly if asked.
   task automatic wait_idle(input logic rnd_req);
      int n;
      n = 0;
      while ((mif.busy || m_rem != 0) && n < 40) begin
         mif.req = rnd_req ? ($urandom_range(0, 3) == 0) : 1'b0;
         step();
         n++;
      end
      mif.req = 1'b0;
      if (n >= 40) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL wait_idle_timeout: busy=%b after %0d cycles, required 0", mif.busy, n);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int busy_cnt;
      checks = 0;
      errors = 0;
      chk_en = 1'b0;
      reset  = 1'b1;
      mif.start = 1'b0;
      mif.md_op = MD_NONE;
      mif.SrcA  = '0;
      mif.SrcB  = '0;
      mif.req   = 1'b0;
      step();
      step();
      chk_en = 1'b1;
      reset  = 1'b0;
      chk("reset_busy", {31'd0, mif.busy}, 32'd0);
      chk("reset_hi", mif.HI, 32'd0);
      chk("reset_lo", mif.LO, 32'd0);

      // T1 mult with busy length pinned
      drive(MD_MULT, 1'b1, 32'hFFFF_FFFF, 32'd2, 1'b0);
      busy_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         if (mif.busy) busy_cnt++;
         step();
      end
      chk("t1_busy_len", busy_cnt, MC);
      chk("t1_hi", mif.HI, 32'hFFFF_FFFF);
      chk("t1_lo", mif.LO, 32'hFFFF_FFFE);

      // T2 multu
      drive(MD_MULTU, 1'b1, 32'hFFFF_FFFF, 32'd2, 1'b0);
      wait_idle(1'b0);
      chk("t2_hi", mif.HI, 32'h0000_0001);
      chk("t2_lo", mif.LO, 32'hFFFF_FFFE);

      // T3 div / divu / overflow corner
      drive(MD_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
      busy_cnt = 0;
      for (int i = 0; i < 14; i++) begin
         if (mif.busy) busy_cnt++;
         step();
      end
      chk("t3_div_busy_len", busy_cnt, DC);
      chk("t3_div_lo", mif.LO, 32'hFFFF_FFFD);
      chk("t3_div_hi", mif.HI, 32'hFFFF_FFFF);
      drive(MD_DIVU, 1'b1, 32'd7, 32'd2, 1'b0);
      wait_idle(1'b0);
      chk("t3_divu_lo", mif.LO, 32'd3);
      chk("t3_divu_hi", mif.HI, 32'd1);
      drive(MD_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      wait_idle(1'b0);
      chk("t3_ovf_lo", mif.LO, 32'h8000_0000);
      chk("t3_ovf_hi", mif.HI, 32'd0);

      // T4 divide by zero leaves HI/LO alone
      drive(MD_MTHI, 1'b0, 32'h1111, 32'd0, 1'b0);
      drive(MD_MTLO, 1'b0, 32'h2222, 32'd0, 1'b0);
      chk("t4_mthi", mif.HI, 32'h1111);
      chk("t4_mtlo", mif.LO, 32'h2222);
      drive(MD_DIV, 1'b1, 32'd5, 32'd0, 1'b0);
      busy_cnt = 0;
      for (int i = 0; i < 14; i++) begin
         if (mif.busy) busy_cnt++;
         step();
      end
      chk("t4_busy_len", busy_cnt, DC);
      chk("t4_hi", mif.HI, 32'h1111);
      chk("t4_lo", mif.LO, 32'h2222);

      // T5 flush
      drive(MD_MULT, 1'b1, 32'd3, 32'd4, 1'b1);
      chk("t5_flush_busy", {31'd0, mif.busy}, 32'd0);
      chk("t5_flush_lo", mif.LO, 32'h2222);
      drive(MD_MTLO, 1'b0, 32'hDEAD, 32'd0, 1'b1);
      chk("t5_mtlo_req_lo", mif.LO, 32'h2222);
      drive(MD_MULT, 1'b1, 32'd3, 32'd4, 1'b0);
      mif.req = 1'b1;
      for (int i = 0; i < 8; i++) step();
      mif.req = 1'b0;
      chk("t5_req_run_lo", mif.LO, 32'd12);
      chk("t5_req_run_hi", mif.HI, 32'd0);

      // T6 reset mid-op
      drive(MD_MTHI, 1'b0, 32'h5555, 32'd0, 1'b0);
      drive(MD_DIVU, 1'b1, 32'd100, 32'd7, 1'b0);
      step();
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("t6_busy", {31'd0, mif.busy}, 32'd0);
      chk("t6_hi", mif.HI, 32'd0);
      chk("t6_lo", mif.LO, 32'd0);
      for (int i = 0; i < 12; i++) step();
      chk("t6_no_commit_lo", mif.LO, 32'd0);

      // Random traffic, checked every cycle by the compare process
      for (int n = 0; n < 300; n++) begin
         md_op_e      op;
         logic [31:0] a, b;
         logic        rq;
         op = md_op_e'($urandom_range(0, 6));
         a  = $urandom();
         b  = $urandom();
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: b = 32'hFFFF_FFFF;
            2: a = 32'h8000_0000;
            3: b = $urandom_range(1, 9);
            default: ;
         endcase
         rq = ($urandom_range(0, 7) == 0);
         drive(op, is_md_start(op), a, b, rq);
         wait_idle(1'b1);
      end

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
